// File: rtl/arbitro_pkg.sv
// Shared definitions for the BCD transmission arbiter: FSM state encoding,
// the BCD byte width and the width helper used for requester indices.
package arbitro_pkg;

  localparam int BCD_W = 8;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DISPARA  = 2'd1,
    AGUARDA  = 2'd2,
    FINALIZA = 2'd3
  } estado_t;

  // Number of bits needed to index n items, never less than one bit.
  function automatic int largura_id(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seletor_round_robin.sv
// Combinational round-robin selector: starting at the index right after
// the last winner and wrapping around, picks the first active request.
module seletor_round_robin
  import arbitro_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = largura_id(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ultimo,
  output logic             tem_pedido,
  output logic [ID_W-1:0]  vencedor
);

  // Scan from the farthest offset down to the nearest one, so the closest
  // active requester after the last winner is the one that sticks.
  always_comb begin
    tem_pedido = 1'b0;
    vencedor   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(ultimo) + k) % N_REQ]) begin
        tem_pedido = 1'b1;
        vencedor   = ID_W'((int'(ultimo) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/arbitro_transmissao_bcd.sv
// Round-robin arbiter sharing one BCD-to-ASCII serial transmitter among
// N_REQ requesters. Latches the winner and its byte, fires the start pulse,
// waits for completion and acknowledges the winner.
// Optional feature: define ARBITRO_TIMEOUT_EN to abort transfers that wait
// TIMEOUT_CICLOS cycles without pronto_tx, flagging them with erro_timeout.
module arbitro_transmissao_bcd
  import arbitro_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req,
  input  logic [BCD_W*N_REQ-1:0]         bcd_in,
  output logic [N_REQ-1:0]               ack,
  output logic [largura_id(N_REQ)-1:0]   grant_id,
  output logic                           ocupado,
  output logic [BCD_W-1:0]               bcd,
  output logic                           transmite_bcd,
  input  logic                           pronto_tx,
  output logic                           erro_timeout
);

  localparam int ID_W = largura_id(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CICLOS < 2) begin : g_config_invalida
    $error("arbitro_transmissao_bcd: N_REQ must be 2..8 and TIMEOUT_CICLOS >= 2");
  end

  estado_t         estado;
  estado_t         proximo;
  logic [ID_W-1:0] ultimo;
  logic            tem_pedido;
  logic [ID_W-1:0] vencedor;
  logic            estouro;

  seletor_round_robin #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_seletor (
    .req        (req),
    .ultimo     (ultimo),
    .tem_pedido (tem_pedido),
    .vencedor   (vencedor)
  );

`ifdef ARBITRO_TIMEOUT_EN
  localparam int CONT_W = largura_id(TIMEOUT_CICLOS);

  logic [CONT_W-1:0] contador;
  logic              erro_reg;

  assign estouro = (contador == CONT_W'(TIMEOUT_CICLOS - 1));

  // Wait-time counter: zero outside AGUARDA, so every entry starts at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contador <= '0;
    end else if (estado == AGUARDA) begin
      contador <= contador + 1'b1;
    end else begin
      contador <= '0;
    end
  end

  // Remembers whether AGUARDA was left by timeout rather than by pronto_tx.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_reg <= 1'b0;
    end else if (estado == AGUARDA) begin
      erro_reg <= estouro && !pronto_tx;
    end
  end
`else
  assign estouro = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // Winner and byte latch, taken only when a transfer starts so that
  // bcd_in changes during the transfer have no effect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ultimo   <= ID_W'(N_REQ - 1);
      grant_id <= '0;
      bcd      <= '0;
    end else if (estado == OCIOSO && tem_pedido) begin
      ultimo   <= vencedor;
      grant_id <= vencedor;
      bcd      <= bcd_in[int'(vencedor)*BCD_W +: BCD_W];
    end
  end

  // Next-state logic; pronto_tx only matters while waiting in AGUARDA.
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:   if (tem_pedido) proximo = DISPARA;
      DISPARA:  proximo = AGUARDA;
      AGUARDA:  if (pronto_tx || estouro) proximo = FINALIZA;
      FINALIZA: proximo = OCIOSO;
      default:  proximo = OCIOSO;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ack           = '0;
    transmite_bcd = 1'b0;
    ocupado       = (estado != OCIOSO);
    erro_timeout  = 1'b0;
    case (estado)
      DISPARA:  transmite_bcd = 1'b1;
      FINALIZA: begin
        ack[grant_id] = 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
        erro_timeout  = erro_reg;
`endif
      end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_arbitro_transmissao_bcd.sv
// Self-checking bench for arbitro_transmissao_bcd: directed scenarios plus
// randomized transfers compared against a transaction-level round-robin model.
// Build with ARBITRO_TIMEOUT_EN defined to exercise the timeout path.
module tb_arbitro_transmissao_bcd;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] bcd_in = '0;
  logic           pronto_tx = 1'b0;
  logic [N-1:0]   ack;
  logic [1:0]     grant_id;
  logic           ocupado;
  logic [7:0]     bcd;
  logic           transmite_bcd;
  logic           erro_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int ultimo_m = N - 1;

  arbitro_transmissao_bcd #(
    .N_REQ          (N),
    .TIMEOUT_CICLOS (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .bcd_in        (bcd_in),
    .ack           (ack),
    .grant_id      (grant_id),
    .ocupado       (ocupado),
    .bcd           (bcd),
    .transmite_bcd (transmite_bcd),
    .pronto_tx     (pronto_tx),
    .erro_timeout  (erro_timeout)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference rule: first active request after the last winner, wrapping.
  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic randomize_bytes();
    for (int i = 0; i < N; i++) bcd_in[8*i +: 8] = 8'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ack"}, 32'(ack), 32'd0);
    check_output({tag, "_tx"}, 32'(transmite_bcd), 32'd0);
    check_output({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    check_output({tag, "_erro"}, 32'(erro_timeout), 32'd0);
    check_output({tag, "_grant"}, 32'(grant_id), 32'd0);
    check_output({tag, "_bcd"}, 32'(bcd), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    req = '0;
    pronto_tx = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b1;
    ultimo_m = N - 1;
  endtask

  // One full transfer: request, start, d wait cycles ending in pronto_tx, ack.
  task automatic apply_stimulus(input logic [N-1:0] add_req, input int d, input bit keep,
                                input bit drop_early, input bit glitch, output int w);
    logic [N-1:0] a;
    logic [7:0]   exp_byte;
    a = add_req;
    if ((req | a) == '0) a = N'(1) << $urandom_range(0, N - 1);
    tick();
    req = req | a;
    pronto_tx = 1'b0;
    w = rr_winner(req, ultimo_m);
    exp_byte = bcd_in[8*w +: 8];
    sample();
    check_output("idle_ocupado", 32'(ocupado), 32'd0);
    check_output("idle_tx", 32'(transmite_bcd), 32'd0);
    tick();
    pronto_tx = glitch;
    randomize_bytes();
    sample();
    check_output("start_tx", 32'(transmite_bcd), 32'd1);
    check_output("start_grant", 32'(grant_id), 32'(w));
    check_output("start_bcd", 32'(bcd), 32'(exp_byte));
    check_output("start_ocupado", 32'(ocupado), 32'd1);
    for (int k = 0; k < d; k++) begin
      tick();
      pronto_tx = (k == d - 1);
      randomize_bytes();
      if (drop_early && k == 0) req[w] = 1'b0;
      sample();
      check_output("wait_tx", 32'(transmite_bcd), 32'd0);
      check_output("wait_bcd", 32'(bcd), 32'(exp_byte));
      check_output("wait_ack", 32'(ack), 32'd0);
      check_output("wait_ocupado", 32'(ocupado), 32'd1);
    end
    tick();
    pronto_tx = 1'b0;
    if (!keep) req[w] = 1'b0;
    sample();
    check_output("ack", 32'(ack), 32'(N'(1) << w));
    check_output("ack_erro", 32'(erro_timeout), 32'd0);
    check_output("ack_bcd", 32'(bcd), 32'(exp_byte));
    ultimo_m = w;
  endtask

  initial begin
    int w;
    int ordem [5] = '{0, 1, 2, 3, 0};

    // Reset state
    #2;
    check_all_zero("por");
    do_reset();

    // Single request carrying 0x42
    bcd_in = '0;
    bcd_in[7:0] = 8'h42;
    apply_stimulus(4'b0001, 3, 1'b0, 1'b0, 1'b0, w);
    check_output("first_winner", 32'(w), 32'd0);
    check_output("first_byte", 32'(bcd), 32'h42);
    tick();
    sample();
    check_output("ocupado_falls", 32'(ocupado), 32'd0);

    // All four requesting: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'b1111, 1 + (i % 3), 1'b1, 1'b0, 1'b0, w);
      check_output("order", 32'(w), 32'(ordem[i]));
    end
    req = '0;

    // Wrap-around: last winner 1, requests 1001 -> 3 before 0
    do_reset();
    apply_stimulus(4'b0010, 2, 1'b0, 1'b0, 1'b0, w);
    apply_stimulus(4'b1001, 2, 1'b0, 1'b0, 1'b0, w);
    check_output("wrap_first", 32'(w), 32'd3);
    apply_stimulus(4'b0000, 2, 1'b0, 1'b0, 1'b0, w);
    check_output("wrap_second", 32'(w), 32'd0);

    // Reset pulled low while waiting for the transmitter
    do_reset();
    tick();
    req = 4'b0010;
    sample();
    tick();
    sample();
    check_output("mid_start_tx", 32'(transmite_bcd), 32'd1);
    tick();
    sample();
    check_output("mid_wait_ocupado", 32'(ocupado), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    pronto_tx = 1'b1;
    sample();
    check_output("mid_no_ack", 32'(ack), 32'd0);
    tick();
    pronto_tx = 1'b0;
    reset = 1'b1;
    req = '0;
    ultimo_m = N - 1;
    apply_stimulus(4'b0010, 2, 1'b0, 1'b0, 1'b0, w);
    check_output("mid_served", 32'(w), 32'd1);

    // Transmitter never answers
    tick();
    req = 4'b0100;
    w = rr_winner(req, ultimo_m);
    sample();
    tick();
    sample();
    check_output("to_start", 32'(transmite_bcd), 32'd1);
`ifdef ARBITRO_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      tick();
      sample();
      check_output("to_wait_ack", 32'(ack), 32'd0);
    end
    tick();
    req[w] = 1'b0;
    sample();
    check_output("to_ack", 32'(ack), 32'(N'(1) << w));
    check_output("to_erro", 32'(erro_timeout), 32'd1);
    ultimo_m = w;
    tick();
    sample();
    check_output("to_idle", 32'(ocupado), 32'd0);
    check_output("to_erro_off", 32'(erro_timeout), 32'd0);
`else
    for (int k = 0; k < 3 * TO; k++) begin
      tick();
      sample();
      check_output("hold_ocupado", 32'(ocupado), 32'd1);
      check_output("hold_erro", 32'(erro_timeout), 32'd0);
      check_output("hold_ack", 32'(ack), 32'd0);
    end
    do_reset();
`endif

    // Randomized transfers against the model
    req = '0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(N'($urandom), $urandom_range(1, 6), 1'($urandom),
                     ($urandom_range(0, 7) == 0), 1'($urandom), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
